// File: rtl/rom_uart_loader.sv
// UART program loader: receives an 8N1 image (16-bit word count + little-endian words) and writes it
// into the instruction ROM, holding the core in reset until done. Optional trailer sum: LOADER_CHECKSUM_EN.
module rom_uart_loader #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int ROM_DEPTH = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    input  logic              reload,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);
    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             cnt_full, half_hit, byte_vld, frame_err;
    logic [7:0]       rx_byte;

    ld_state_t        state_q, state_d;
    logic [7:0]       len_lo_q;
    logic [15:0]      len_q;
    logic [15:0]      hdr_len;
    logic [ADDR_W-1:0] word_idx_q;
    logic [1:0]       byte_cnt_q;
    logic [23:0]      word_q;
    logic             last_word;
    logic             rom_we_q;
    logic [ADDR_W-1:0] rom_waddr_q;
    logic [31:0]      rom_wdata_q;
    logic             core_rst_n_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum_q;
`endif

    assign cnt_full = (cnt_q == CNT_W'(CPB - 1));
    assign half_hit = (cnt_q == CNT_W'(HALF - 1));
    assign rx_byte  = shift_q;

    // UART receiver: state register and bit-timing datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            case (rx_state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                end
                RX_START: cnt_q <= half_hit ? '0 : cnt_q + 1'b1;
                RX_DATA: begin
                    if (cnt_full) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: cnt_q <= cnt_full ? '0 : cnt_q + 1'b1;
            endcase
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            RX_START: if (half_hit) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_full && bit_q == 3'd7) rx_state_d = RX_STOP;
            default:  if (cnt_full) rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_vld  = (rx_state_q == RX_STOP) && cnt_full && rx_sync_q;
        frame_err = (rx_state_q == RX_STOP) && cnt_full && !rx_sync_q;
    end

    // Loader FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= L_LEN0;
        else        state_q <= state_d;
    end

    assign hdr_len   = {rx_byte, len_lo_q};
    assign last_word = (16'(word_idx_q) == len_q - 16'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            L_LEN0: begin
                if (frame_err)     state_d = L_ERR;
                else if (byte_vld) state_d = L_LEN1;
            end
            L_LEN1: begin
                if (frame_err) state_d = L_ERR;
                else if (byte_vld) begin
                    if (hdr_len == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                        state_d = L_CSUM;
`else
                        state_d = L_DONE;
`endif
                    else if (32'(hdr_len) > ROM_DEPTH) state_d = L_ERR;
                    else                               state_d = L_DATA;
                end
            end
            L_DATA: begin
                if (frame_err) state_d = L_ERR;
                else if (byte_vld && byte_cnt_q == 2'd3 && last_word)
`ifdef LOADER_CHECKSUM_EN
                    state_d = L_CSUM;
`else
                    state_d = L_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            L_CSUM: begin
                if (frame_err)     state_d = L_ERR;
                else if (byte_vld) state_d = (rx_byte == sum_q) ? L_DONE : L_ERR;
            end
`endif
            L_DONE, L_ERR: if (reload) state_d = L_LEN0;
            default: state_d = L_ERR;
        endcase
    end

    // Loader datapath: header capture, word assembly, ROM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q     <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            rom_we_q     <= 1'b0;
            rom_waddr_q  <= '0;
            rom_wdata_q  <= '0;
            core_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            rom_we_q     <= 1'b0;
            core_rst_n_q <= (state_q == L_DONE) && !reload;
            case (state_q)
                L_LEN0: if (byte_vld) len_lo_q <= rx_byte;
                L_LEN1: begin
                    if (byte_vld) begin
                        len_q      <= hdr_len;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                L_DATA: begin
                    if (byte_vld) begin
`ifdef LOADER_CHECKSUM_EN
                        sum_q <= sum_q + rx_byte;
`endif
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= rx_byte;
                            2'd1: word_q[15:8]  <= rx_byte;
                            2'd2: word_q[23:16] <= rx_byte;
                            default: begin
                                rom_we_q    <= 1'b1;
                                rom_waddr_q <= word_idx_q;
                                rom_wdata_q <= {rx_byte, word_q};
                                if (!last_word) word_idx_q <= word_idx_q + 1'b1;
                            end
                        endcase
                    end
                end
                L_DONE, L_ERR: begin
                    if (reload) begin
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rom_we     = rom_we_q;
        rom_waddr  = rom_waddr_q;
        rom_wdata  = rom_wdata_q;
        core_rst_n = core_rst_n_q;
        done       = (state_q == L_DONE);
        err        = (state_q == L_ERR);
    end
endmodule
